// File: rtl/matmul_seq_pkg.sv
// ---------------------------------------------------------------------------
// matmul_seq_pkg
// Shared types and helpers for the systolic matrix-multiply sequencer.
//   seq_state_t   : sequencer FSM state encoding
//   stream_cycles : number of cycles the array enable stays high for a
//                   DIM x DIM multiply (operand skew plus propagation)
// ---------------------------------------------------------------------------
package matmul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        READ   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // DIM operand rows enter with up to DIM-1 cycles of skew, and the last
    // product then needs DIM-1 more cycles to ripple to the far corner PE.
    function automatic int stream_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/matmul_seq_counter.sv
// ---------------------------------------------------------------------------
// matmul_seq_counter
// Loadable up-counter shared by the STREAM and READ phases of the sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load the counter with zero (wins over inc)
//   inc        : increment by one
//   tc_val     : terminal-count value to compare the current count against
//   cnt_next   : value the counter will hold after the next clock edge
//   tc         : current count equals tc_val
// ---------------------------------------------------------------------------
module matmul_seq_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt_next,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The look-ahead value lets the owner register outputs that line up
    // with the count rather than lagging it by a cycle.
    assign cnt_next = cnt_d;
    assign tc       = (cnt_q == tc_val);

endmodule

// File: rtl/matmul_seq.sv
// ---------------------------------------------------------------------------
// matmul_seq
// Sequencer for one DIM x DIM systolic matrix multiply: clears the PE
// accumulators, streams DIM operand rows while holding the array enable for
// the full skew-plus-propagation window, reads DIM result rows, pulses done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (only looked at in IDLE)
//   abort      : synchronous cancel back to IDLE
//   busy       : high whenever not IDLE
//   done       : one-cycle completion pulse
//   clr        : one-cycle accumulator clear / feeder restart
//   en         : feeder and PE array enable
//   op_rd      : operand-row read strobe, op_row its index
//   c_rd       : result-row read strobe, c_row its index
// All outputs are registered.
// ---------------------------------------------------------------------------
module matmul_seq
    import matmul_seq_pkg::*;
#(
    parameter int DIM        = 8,
    parameter int STREAM_CYC = stream_cycles(DIM),
    parameter int CNT_W      = $clog2(3 * DIM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   clr,
    output logic                   en,
    output logic                   op_rd,
    output logic [$clog2(DIM)-1:0] op_row,
    output logic                   c_rd,
    output logic [$clog2(DIM)-1:0] c_row
);

    localparam int ROW_W = $clog2(DIM);

    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] DIM_CNT     = CNT_W'(DIM);

    seq_state_t state_q, state_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_tc_val;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_tc;

    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             clr_q,    clr_d;
    logic             en_q,     en_d;
    logic             op_rd_q,  op_rd_d;
    logic [ROW_W-1:0] op_row_q, op_row_d;
    logic             c_rd_q,   c_rd_d;
    logic [ROW_W-1:0] c_row_q,  c_row_d;

    // One counter serves both timed phases; only the terminal value changes.
    assign cnt_tc_val = (state_q == READ) ? READ_LAST : STREAM_LAST;

    matmul_seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .tc_val   (cnt_tc_val),
        .cnt_next (cnt_next),
        .tc       (cnt_tc)
    );

    // Next-state and counter control. Abort outranks everything outside
    // IDLE; in IDLE it merely suppresses a simultaneous start.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = CLEAR;
                        cnt_clr = 1'b1;
                    end
                end
                CLEAR: begin
                    state_d = STREAM;
                    cnt_clr = 1'b1;
                end
                STREAM: begin
                    if (cnt_tc) begin
                        state_d = READ;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                READ: begin
                    if (cnt_tc) begin
                        state_d = DONE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state and count so that, once
    // registered, they line up exactly with the state they describe.
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        clr_d    = (state_d == CLEAR);
        en_d     = (state_d == STREAM);
        op_rd_d  = (state_d == STREAM) && (cnt_next < DIM_CNT);
        op_row_d = '0;
        c_rd_d   = (state_d == READ);
        c_row_d  = '0;

        if (op_rd_d) begin
            op_row_d = cnt_next[ROW_W-1:0];
        end
        if (c_rd_d) begin
            c_row_d = cnt_next[ROW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            op_rd_q  <= 1'b0;
            op_row_q <= '0;
            c_rd_q   <= 1'b0;
            c_row_q  <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
            en_q     <= en_d;
            op_rd_q  <= op_rd_d;
            op_row_q <= op_row_d;
            c_rd_q   <= c_rd_d;
            c_row_q  <= c_row_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign clr    = clr_q;
    assign en     = en_q;
    assign op_rd  = op_rd_q;
    assign op_row = op_row_q;
    assign c_rd   = c_rd_q;
    assign c_row  = c_row_q;

endmodule

// File: tb/tb_matmul_seq.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq
// Drives a DIM=8 and a DIM=2 sequencer from the same start/abort stimulus
// and compares every cycle against a timeline model: each instance keeps the
// number of cycles since its start was accepted, and the expected outputs
// are derived from that age with the latency arithmetic of the block.
// ---------------------------------------------------------------------------
module tb_matmul_seq;
    import matmul_seq_pkg::*;

    localparam int TOTAL8 = 2 + stream_cycles(8) + 8;
    localparam int TOTAL2 = 2 + stream_cycles(2) + 2;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;

    logic       busy8, done8, clr8, en8, op_rd8, c_rd8;
    logic [2:0] op_row8, c_row8;
    logic       busy2, done2, clr2, en2, op_rd2, c_rd2;
    logic [0:0] op_row2, c_row2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: age of the running operation in cycles (0 = IDLE).
    int age8 = 0;
    int age2 = 0;

    matmul_seq #(.DIM(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .busy   (busy8),
        .done   (done8),
        .clr    (clr8),
        .en     (en8),
        .op_rd  (op_rd8),
        .op_row (op_row8),
        .c_rd   (c_rd8),
        .c_row  (c_row8)
    );

    matmul_seq #(.DIM(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .busy   (busy2),
        .done   (done2),
        .clr    (clr2),
        .en     (en2),
        .op_rd  (op_rd2),
        .op_row (op_row2),
        .c_rd   (c_rd2),
        .c_row  (c_row2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs8, obs2;
    assign obs8 = {4'b0, busy8, done8, clr8, en8, op_rd8, op_row8, c_rd8, c_row8};
    assign obs2 = {4'b0, busy2, done2, clr2, en2, op_rd2, 2'b0, op_row2,
                   c_rd2, 2'b0, c_row2};

    // Expected packed outputs for an operation that is t cycles old.
    function automatic logic [15:0] expWord(input int t, input int dim);
        int         sc;
        int         total;
        logic       e_busy, e_done, e_clr, e_en, e_op_rd, e_c_rd;
        logic [2:0] e_op_row, e_c_row;
        sc       = stream_cycles(dim);
        total    = 2 + sc + dim;
        e_busy   = (t >= 1) && (t <= total);
        e_done   = (t == total);
        e_clr    = (t == 1);
        e_en     = (t >= 2) && (t < 2 + sc);
        e_op_rd  = (t >= 2) && (t < 2 + dim);
        e_op_row = e_op_rd ? 3'(t - 2) : 3'd0;
        e_c_rd   = (t >= 2 + sc) && (t < 2 + sc + dim);
        e_c_row  = e_c_rd ? 3'(t - 2 - sc) : 3'd0;
        return {4'b0, e_busy, e_done, e_clr, e_en, e_op_rd, e_op_row, e_c_rd, e_c_row};
    endfunction

    function automatic int nextAge(input int t, input logic s, input logic a,
                                   input int total);
        if (t == 0) return (s && !a) ? 1 : 0;
        if (a) return 0;
        if (t >= total) return 0;
        return t + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Hold the given inputs for n cycles, changing them on the falling edge.
    task automatic applyStimulus(input logic s, input logic a, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = s;
            abort = a;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age8 = 0;
            age2 = 0;
        end else begin
            age8 = nextAge(age8, start, abort, TOTAL8);
            age2 = nextAge(age2, start, abort, TOTAL2);
        end
    end

    always @(negedge clk) begin
        checkOutput("dim8_cycle", obs8, expWord(age8, 8));
        checkOutput("dim2_cycle", obs2, expWord(age2, 2));
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        applyStimulus(1'b0, 1'b0, 3);
        rst_n = 1'b1;

        $display("[TB] idle after reset");
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] nominal single operation");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 36);

        $display("[TB] start held high");
        applyStimulus(1'b1, 1'b0, 70);
        applyStimulus(1'b0, 1'b0, 5);

        $display("[TB] abort during stream");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 36);

        $display("[TB] abort with start in idle");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] asynchronous reset during read");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 26);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_dim8", obs8, 16'h0000);
        checkOutput("async_rst_dim2", obs2, 16'h0000);
        applyStimulus(1'b0, 1'b0, 2);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10);

        $display("[TB] random start/abort traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 24) == 0, 1);
        end
        applyStimulus(1'b0, 1'b0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
